// File: rtl/mux_n1_rr_pkg.sv
// mux_n1_rr_pkg: mode encodings and sizing helper shared by the mux_n1_rr files
package mux_n1_rr_pkg;
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR = 1'b1;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/mux_n1_rr_if.sv
// mux_n1_rr_if: producer/consumer bundle of mux_n1_rr; out_ch exists only with MUX_N1_RR_TAG_EN
interface mux_n1_rr_if import mux_n1_rr_pkg::*; #(
    parameter int CH = 4,
    parameter int WIDTH = 8
);
    localparam int SELW = clog2(CH);
    logic [CH*WIDTH-1:0] in_data;
    logic [CH-1:0] in_valid;
    logic [CH-1:0] in_ready;
    logic [SELW-1:0] sel;
    logic mode;
    logic [WIDTH-1:0] out_data;
    logic out_valid;
    logic out_ready;
`ifdef MUX_N1_RR_TAG_EN
    logic [SELW-1:0] out_ch;
`endif
    modport master (
`ifdef MUX_N1_RR_TAG_EN
        input out_ch,
`endif
        output in_data, in_valid, sel, mode, out_ready,
        input in_ready, out_data, out_valid
    );
    modport slave (
`ifdef MUX_N1_RR_TAG_EN
        output out_ch,
`endif
        input in_data, in_valid, sel, mode, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/mux_n1_rr_rr_pick.sv
// rr_pick: combinational round-robin finder (rotate by ptr, lowest set bit, rotate back)
module rr_pick import mux_n1_rr_pkg::*; #(
    parameter int CH = 4,
    localparam int SELW = clog2(CH)
) (
    input  logic [CH-1:0]   req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic [SELW-1:0] gnt_idx_o,
    output logic            gnt_vld_o
);
    logic [2*CH-1:0] dbl;
    logic [CH-1:0] rot;
    int k;
    int s;
    always_comb begin
        dbl = {req_i, req_i} >> ptr_i;
        rot = dbl[CH-1:0];
        gnt_vld_o = |rot;
        k = 0;
        for (int i = CH - 1; i >= 0; i--) k = rot[i] ? i : k;
        s = k + int'(ptr_i);
        gnt_idx_o = SELW'(s >= CH ? s - CH : s);
    end
endmodule

// File: rtl/mux_n1_rr.sv
// mux_n1_rr: CH:1 valid/ready mux with registered output, manual select or round-robin grant
// Define MUX_N1_RR_TAG_EN to add out_ch, the source channel of the registered word.
module mux_n1_rr import mux_n1_rr_pkg::*; #(
    parameter int CH = 4,
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst,
    mux_n1_rr_if.slave io
);
    localparam int SELW = clog2(CH);
    logic [WIDTH-1:0] ch_data [CH];
    logic [(1 << SELW)-1:0] vld_pad;
    logic [SELW-1:0] rr_idx, gnt, ptr_q, ptr_d;
    logic rr_vld, gnt_vld, load_ok, fire;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic out_valid_q, out_valid_d;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        assign ch_data[c] = io.in_data[c*WIDTH +: WIDTH];
    end

    rr_pick #(.CH(CH)) u_pick (
        .req_i(io.in_valid),
        .ptr_i(ptr_q),
        .gnt_idx_o(rr_idx),
        .gnt_vld_o(rr_vld)
    );

    // valid padded to a power of two so an out-of-range sel reads as "not valid"
    always_comb begin
        vld_pad = '0;
        vld_pad[CH-1:0] = io.in_valid;
        load_ok = !out_valid_q || io.out_ready;
        gnt = io.mode == MODE_RR ? rr_idx : io.sel;
        gnt_vld = io.mode == MODE_RR ? rr_vld : vld_pad[io.sel];
        fire = !rst && load_ok && gnt_vld;
        io.in_ready = fire ? CH'(1) << gnt : '0;
        ptr_d = (fire && io.mode == MODE_RR) ? (int'(gnt) == CH - 1 ? '0 : gnt + 1'b1) : ptr_q;
        out_valid_d = fire || (out_valid_q && !io.out_ready);
        out_data_d = fire ? ch_data[gnt] : out_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.out_data = out_data_q;

`ifdef MUX_N1_RR_TAG_EN
    logic [SELW-1:0] out_ch_q, out_ch_d;
    assign out_ch_d = fire ? gnt : out_ch_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_ch_q <= '0;
        else out_ch_q <= out_ch_d;
    end
    assign io.out_ch = out_ch_q;
`endif
endmodule

// File: doc/mux_n1_rr.md
Name: mux_n1_rr

Overview:
- Parametrised N-channel, W-bit multiplexer with valid/ready handshake on every input and the output.
- Registered output; next generation of the team's 4:1 bit mux.
- Two modes:
  - manual: a select port picks one channel.
  - round-robin: scans channels and grants the next valid one.
- Sits between multiple producer channels and a single consumer.

Parameters:
- CH, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel.
- SELW, $clog2(CH), width of select/pointer fields (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  CH  per-channel valid.
- in_ready  out  CH  per-channel ready; at most one bit high.
- sel  in  SELW  channel select, used in manual mode.
- mode  in  1  0 = manual, 1 = round-robin.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  output holds a word.
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset: asynchronous, active-high; the clock and reset arrangement is fixed.
  - Asserting rst clears out_valid=0, out_data=0 and the rr pointer=0 immediately.
  - in_ready is combinational, so it is all-zero during reset.
  - A word held in the output register is dropped; there is no partial transfer.
- Output register: 1 entry. load_ok = !out_valid || out_ready.
- Grant, computed combinationally each cycle:
  - Manual: grant = sel when sel < CH and in_valid[sel]=1; otherwise no grant.
  - If sel >= CH, all in_ready=0 and there is no load.
  - Round-robin: grant = first i with in_valid[i]=1, searching ptr, ptr+1, … modulo CH; no grant if every in_valid=0.
- in_ready[g] = load_ok && granted(g); all other bits are 0.
- Transfer on channel g happens when in_valid[g] && in_ready[g].
  - On that edge: out_data <= channel g data and out_valid <= 1.
  - In round-robin mode, ptr <= (g==CH-1) ? 0 : g+1, wrapping at CH.
- Output drain: out_valid && out_ready with no new transfer sets out_valid <= 0; out_data holds its value.
- Simultaneous drain and load: the new word replaces the old one in the same cycle, giving full throughput of 1 word/clk.
- Latency: 1 clk from input transfer to out_valid.
- Stall: out_valid=1 and out_ready=0 hold out_data and out_valid stable and keep all in_ready=0.
- Mode or sel change:
  - Takes effect in the grant logic of the same cycle.
  - Never affects a word already registered.
  - ptr is not updated in manual mode and keeps its value across mode switches.
- Inputs must hold data stable while valid is high and ready is low (producer rule).

Optional Feature:
- Macro MUX_N1_RR_TAG_EN.
- Defined: adds port out_ch (out, SELW) = index of the source channel of out_data. It is loaded together with out_data, reset value 0, and held stable while stalled.
- Undefined: the port is absent and no tag register is built.

Decomposition:
- Shared package/header mux_pkg holds:
  - MODE_MANUAL=1'b0 and MODE_RR=1'b1.
  - A clog2 helper function.
- Sub-module rr_pick: purely combinational.
  - Inputs: req[CH], ptr[SELW].
  - Outputs: gnt_idx[SELW], gnt_vld.
  - Implemented as a rotate / priority-find / un-rotate.
- The top level holds the output register, ptr register and handshake logic.

Test Plan (CH=4, WIDTH=8):
- Reset mid-stall:
  - Stimulus: load 8'hA5 with out_ready=0, then assert rst asynchronously (between clock edges).
  - Response: out_valid=0 and out_data=0 at once; after release, ptr=0 with no spurious output.
- Manual select sweep:
  - Stimulus: mode=0, in_data ch0..3 = 11,22,33,44, all valid, out_ready=1; sel = 0,1,2,3 on successive cycles.
  - Response: out_data = 11,22,33,44, each 1 clk later; only in_ready[sel] is high.
- Manual invalid sel:
  - Stimulus: CH=3 build, sel=3, all valid.
  - Response: in_ready=0 and out_valid never rises.
- Round-robin fairness:
  - Stimulus: mode=1, all 4 valid continuously, out_ready=1.
  - Response: grant order 0,1,2,3,0,… with one word per clk and ptr wrapping 3→0.
- Round-robin skip:
  - Stimulus: only ch1 and ch3 valid.
  - Response: output alternates ch1, ch3, ch1; ch0 and ch2 never get ready.
- Backpressure:
  - Stimulus: out_ready toggles 0,1,0,1 with all channels valid in round-robin mode.
  - Response: no words are lost or duplicated, out_data is stable while stalled, and one word drains per out_ready=1 cycle.
  - With MUX_N1_RR_TAG_EN defined, out_ch matches the source channel.
